// File: rtl/up_sign_sched_pkg.sv
// Shared constants and helpers for the upload-enable scheduler family.
// Holds the default slot timing and the fixed-priority grant used by the release logic.
package up_sign_sched_pkg;

  localparam int NCH_DEF   = 3;
  localparam int FAULT_IDX = NCH_DEF;
  // Widest request vector any instance can have: 8 slot channels plus fault.
  localparam int GW        = 9;

  localparam logic [15:0] SLOT_DEF_0 = 16'd1000;
  localparam logic [15:0] SLOT_DEF_1 = 16'd2000;
  localparam logic [15:0] SLOT_DEF_2 = 16'd3000;

  function automatic logic [15:0] slot_default(input int idx);
    logic [15:0] v;
    case (idx)
      0:       v = SLOT_DEF_0;
      1:       v = SLOT_DEF_1;
      default: v = SLOT_DEF_2;
    endcase
    return v;
  endfunction

  // One-hot grant: bit fidx wins outright, otherwise the lowest set bit below it.
  function automatic logic [GW-1:0] prio_grant(input logic [GW-1:0] req, input int fidx);
    logic [GW-1:0] g;
    logic          found;
    g     = '0;
    found = 1'b0;
    if (req[fidx]) begin
      g[fidx] = 1'b1;
    end else begin
      for (int i = 0; i < GW; i++) begin
        if (!found && (i < fidx) && req[i]) begin
          g[i]  = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/up_sign_edge.sv
// Two-flop synchroniser with a rising-edge detector on the synchronised level.
// The edge pulse is combinational from the second and third flops.
module up_sign_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/up_sign_sched.sv
// Upload-enable scheduler: per-slot timer hits plus a fault edge, released one per
// cycle in fixed priority whenever the bit strobe is low and the transmitter is idle.
module up_sign_sched
  import up_sign_sched_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int TW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TW-1:0]     t_data,
  input  logic [NCH*TW-1:0] slot_cfg,
  input  logic              clk1x_en,
  input  logic              tx_busy,
  input  logic              fault,
  output logic [NCH-1:0]    slot_en,
  output logic              fault_en,
  output logic [NCH:0]      pend,
  output logic [NCH:0]      ovr,
  input  logic [NCH:0]      ovr_clr
);

  localparam int FI = NCH;

  logic [NCH-1:0] match;
  logic [NCH-1:0] match_d;
  logic           fault_rise;
  logic [NCH:0]   hit;
  logic [NCH:0]   req;
  logic [NCH:0]   grant;
  logic [GW-1:0]  grant_full;
  logic [NCH:0]   pend_next;
  logic [NCH:0]   ovr_next;
  logic           gate;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_match
      assign match[gi] = (t_data == slot_cfg[gi*TW +: TW]);
      assign hit[gi]   = match[gi] & ~match_d[gi];
    end
  endgenerate

  up_sign_edge u_fault_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (fault),
    .rise (fault_rise)
  );

  assign hit[FI] = fault_rise;

  always_comb begin
    gate       = ~clk1x_en & ~tx_busy;
    req        = pend | hit;
    grant_full = '0;
    if (gate) begin
      grant_full = prio_grant(GW'(req), FI);
    end
    grant     = grant_full[NCH:0];
    pend_next = req & ~grant;
    // A fresh hit on an already-pending request that is not served now is lost;
    // the set term is ORed last so it beats a simultaneous clear.
    ovr_next  = (ovr & ~ovr_clr) | (hit & pend & ~grant);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_d  <= '0;
      slot_en  <= '0;
      fault_en <= 1'b0;
      pend     <= '0;
      ovr      <= '0;
    end else begin
      match_d  <= match;
      slot_en  <= grant[NCH-1:0];
      fault_en <= grant[FI];
      pend     <= pend_next;
      ovr      <= ovr_next;
    end
  end

endmodule

// File: doc/up_sign_sched.md
Name: up_sign_sched

Overview:
- Parametrised upload-enable scheduler: the next generation of the fixed three-slot upload enable generator.
- Each of NCH slot channels raises a one-cycle send enable when the frame timer t_data first reaches its runtime-configured slot value.
- The fault input raises its own send enable on each rising edge.
- All enables are released only in cycles where clk1x_en is low and the downstream transmitter is idle. At most one enable fires per cycle, with fixed priority. Requests that cannot fire wait as pending, and lost requests are flagged.

Parameters:
- NCH, 3, number of timer-slot channels (1..8)
- TW, 16, width of t_data and of each slot compare value

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- t_data  in  TW  frame timer value
- slot_cfg  in  NCH*TW  slot compare values; channel i uses bits [i*TW +: TW]; held static in normal operation
- clk1x_en  in  1  serial bit-rate strobe; a release is allowed only while it is low
- tx_busy  in  1  downstream transmitter busy; a release is allowed only while it is low
- fault  in  1  asynchronous fault level
- slot_en  out  NCH  one-hot send-enable pulses, one bit per slot channel
- fault_en  out  1  fault send-enable pulse
- pend  out  NCH+1  pending requests; bit NCH is fault
- ovr  out  NCH+1  sticky overrun flags; bit NCH is fault
- ovr_clr  in  NCH+1  per-bit clear of ovr

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high. While rst is high, every flop clears: slot_en=0, fault_en=0, pend=0, ovr=0, sync/edge flops=0, match_d=0.
- Slot hit:
  - match_i = (t_data == slot_cfg[i]); match_d_i is match_i registered.
  - hit_i = match_i & ~match_d_i, so only the first cycle of a match counts and a held t_data gives one hit.
  - If t_data equals a slot value on the first cycle after reset release, that is a hit.
- Fault hit:
  - fault passes through a 2-flop synchroniser (s1, s2), then s3 = s2 delayed.
  - hit_F = s2 & ~s3.
  - If fault rises before clock edge E0, hit_F is true in the cycle after E0+1.
- Request vector: req = pend | hit, over bits 0..NCH.
- Gate: gate = ~clk1x_en & ~tx_busy, evaluated in the current cycle.
- Grant: if gate and req≠0, the grant is fixed priority — fault (bit NCH) first, then channel 0, 1, … NCH-1.
- Clock edge update:
  - The granted output pulses high for exactly one cycle: fault_en or slot_en[g].
  - pend[g] clears.
  - Every other req bit is stored into pend.
  - If there is no gate, all outputs are 0 and pend <= req.
- Latency: a hit in cycle n with the gate open in cycle n and no higher-priority request gives an enable high during cycle n+1. Minimum slot latency is 1 cycle; minimum fault latency is 3 cycles from E0.
- Overrun:
  - If hit_k=1 and pend_k=1 in the same cycle and k is not granted that cycle, ovr[k] is set and the request stays single (no counting).
  - If ovr_clr[k] and a set condition occur in the same cycle, set wins.
- Output exclusivity: slot_en and fault_en are mutually exclusive; at most one bit of {fault_en, slot_en} is high per cycle.
- Equal slot values: if two channels share a slot value, both hit together and fire on consecutive gated cycles in priority order.
- Reset mid-operation: pending requests and flags are discarded; nothing is replayed after reset release.

Decomposition:
- Shared package holds:
  - constant FAULT_IDX = NCH;
  - the default slot values 1000, 2000, 3000, used by the top-level tie-off;
  - the function that computes a one-hot fixed-priority grant.
- One natural sub-module, up_sign_edge: 2-flop synchroniser plus rising-edge detector for fault, reused elsewhere for other asynchronous status inputs.

Test Plan:
1. NCH=3, slot_cfg={3000,2000,1000}, clk1x_en=0, tx_busy=0, t_data counts 0..3500 → slot_en = 001, 010, 100, each a one-cycle pulse in the cycle after t_data = 1000, 2000, 3000; pend stays 0.
2. t_data holds at 1000 for 5 cycles, gate open → exactly one slot_en[0] pulse.
3. t_data=1000 with clk1x_en=1 for 4 cycles then 0 → pend[0]=1 during the wait; slot_en[0] high in the cycle after clk1x_en falls.
4. fault rises in the same cycle t_data=2000, gate open → fault_en fires 3 cycles after E0. slot_en[1] fires 1 cycle after the hit, before fault_en, because the fault edge is not yet visible. Repeat with tx_busy=1 across both → when tx_busy drops, fault_en first, then slot_en[1] on the next cycle.
5. tx_busy=1; t_data sweeps to 1000 twice, with a wrap between → ovr[0]=1, a single pend[0]. Assert ovr_clr[0] → ovr[0]=0. Assert ovr_clr[0] in the same cycle as a new overrun → ovr[0] stays 1.
6. rst asserted asynchronously mid-cycle with pend=0101 → all outputs 0 immediately. After release with t_data=1000 → slot_en[0] pulse 1 cycle later.
